// File: rtl/led_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// led_frame_scheduler_if : game-logic, pixel-RAM and WS2812 transmitter handshake
// Revision 1.0
// ============================================================================
interface led_frame_scheduler_if #(
  parameter int ADDR_W       = 6,
  parameter int BITS_PER_LED = 24
);
  logic                    frame_ready;
  logic                    frame_busy;
  logic                    frame_done;
  logic                    pix_rd_en;
  logic [ADDR_W-1:0]       pix_addr;
  logic [BITS_PER_LED-1:0] pix_data;
  logic                    new_bit_rqst;
  logic                    bit_to_transmit;
  logic                    all_bits_shifted;
  logic                    new_frame_rqst;

  modport master (
    input  frame_ready, pix_data, new_bit_rqst, new_frame_rqst,
    output frame_busy, frame_done, pix_rd_en, pix_addr, bit_to_transmit, all_bits_shifted
  );

  modport slave (
    output frame_ready, pix_data, new_bit_rqst, new_frame_rqst,
    input  frame_busy, frame_done, pix_rd_en, pix_addr, bit_to_transmit, all_bits_shifted
  );
endinterface
`default_nettype wire

// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// led_frame_scheduler : fetches GRB pixel words and serialises one frame MSB-first
// Revision 1.0
// ============================================================================
module led_frame_scheduler #(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 6,
  parameter int BITS_PER_LED = 24
) (
  input  wire logic              clk,
  input  wire logic              rst,
  led_frame_scheduler_if.master  bus
);
  localparam int                CNT_W    = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BITS_PER_LED - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] LOAD     = 3'd2;
  localparam logic [2:0] SHIFT    = 3'd3;
  localparam logic [2:0] WAIT_RST = 3'd4;

  logic [2:0]              state;
  logic                    rst_seen;
  logic                    nxt_valid;
  logic                    pend;
  logic                    pf_cap;
  logic [ADDR_W-1:0]       led_idx;
  logic [CNT_W-1:0]        bit_cnt;
  logic [BITS_PER_LED-1:0] shreg;
  logic [BITS_PER_LED-1:0] nxt_pix;
  logic                    frame_busy;
  logic                    frame_done;
  logic                    pix_rd_en;
  logic [ADDR_W-1:0]       pix_addr;
  logic                    all_bits_shifted;
  logic                    take_next;

  // Move to the prefetched pixel: either a held request or a fresh last-bit request.
  assign take_next = (state == SHIFT) && nxt_valid &&
                     (pend || (bus.new_bit_rqst && bit_cnt == LAST_BIT && led_idx != LAST_IDX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      rst_seen         <= 1'b0;
      nxt_valid        <= 1'b0;
      pend             <= 1'b0;
      pf_cap           <= 1'b0;
      led_idx          <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      nxt_pix          <= '0;
      frame_busy       <= 1'b0;
      frame_done       <= 1'b0;
      pix_rd_en        <= 1'b0;
      pix_addr         <= '0;
      all_bits_shifted <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      pf_cap     <= pix_rd_en && (state == SHIFT);
      case (state)
        IDLE: begin
          if ((rst_seen || bus.new_frame_rqst) && bus.frame_ready) begin
            rst_seen   <= 1'b0;
            frame_busy <= 1'b1;
            led_idx    <= '0;
            bit_cnt    <= '0;
            nxt_valid  <= 1'b0;
            pend       <= 1'b0;
            pix_rd_en  <= 1'b1;
            pix_addr   <= '0;
            state      <= FETCH;
          end else if (bus.new_frame_rqst) begin
            rst_seen <= 1'b1;
          end
        end
        FETCH: begin
          pix_rd_en <= 1'b0;
          state     <= LOAD;
        end
        LOAD: begin
          shreg            <= bus.pix_data;
          bit_cnt          <= '0;
          all_bits_shifted <= 1'b0;
          pix_rd_en        <= (led_idx < LAST_IDX);
          if (led_idx < LAST_IDX) pix_addr <= led_idx + 1'b1;
          state            <= SHIFT;
        end
        SHIFT: begin
          pix_rd_en <= 1'b0;
          if (pf_cap) begin
            nxt_pix   <= bus.pix_data;
            nxt_valid <= 1'b1;
          end
          if (take_next) begin
            shreg     <= nxt_pix;
            nxt_valid <= 1'b0;
            pend      <= 1'b0;
            led_idx   <= led_idx + 1'b1;
            bit_cnt   <= '0;
            pix_rd_en <= ((led_idx + 1'b1) < LAST_IDX);
            if ((led_idx + 1'b1) < LAST_IDX) pix_addr <= led_idx + ADDR_W'(2);
          end else if (!pend && bus.new_bit_rqst) begin
            if (bit_cnt != LAST_BIT) begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end else if (led_idx != LAST_IDX) begin
              pend <= 1'b1;
            end else begin
              all_bits_shifted <= 1'b1;
              state            <= WAIT_RST;
            end
          end
        end
        WAIT_RST: begin
          if (bus.new_frame_rqst) begin
            frame_done <= 1'b1;
            frame_busy <= 1'b0;
            rst_seen   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only SHIFT presents data; every other state idles the line low.
  assign bus.bit_to_transmit  = (state == SHIFT) && shreg[BITS_PER_LED-1];
  assign bus.all_bits_shifted = all_bits_shifted;
  assign bus.frame_busy       = frame_busy;
  assign bus.frame_done       = frame_done;
  assign bus.pix_rd_en        = pix_rd_en;
  assign bus.pix_addr         = pix_addr;
endmodule
`default_nettype wire

// File: tb/tb_led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_led_frame_scheduler : scoreboard bench for 2-, 3- and 1-LED schedulers
// Revision 1.0
// ============================================================================
module tb_led_frame_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic frame_ready = 1'b0;
  logic new_bit_rqst = 1'b0;
  logic new_frame_rqst = 1'b0;
  int   sel = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rd_total = 0;
  int   done_total = 0;
  logic [5:0]  rd_log [0:255];
  logic [23:0] mem [0:63];
  logic        exp_q [$];

  led_frame_scheduler_if #(.ADDR_W(6), .BITS_PER_LED(24)) bus0 ();
  led_frame_scheduler_if #(.ADDR_W(6), .BITS_PER_LED(24)) bus1 ();
  led_frame_scheduler_if #(.ADDR_W(6), .BITS_PER_LED(24)) bus2 ();

  led_frame_scheduler #(.NUM_LEDS(2), .ADDR_W(6), .BITS_PER_LED(24)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  led_frame_scheduler #(.NUM_LEDS(3), .ADDR_W(6), .BITS_PER_LED(24)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
  led_frame_scheduler #(.NUM_LEDS(1), .ADDR_W(6), .BITS_PER_LED(24)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  assign bus0.frame_ready    = frame_ready    && (sel == 0);
  assign bus1.frame_ready    = frame_ready    && (sel == 1);
  assign bus2.frame_ready    = frame_ready    && (sel == 2);
  assign bus0.new_bit_rqst   = new_bit_rqst   && (sel == 0);
  assign bus1.new_bit_rqst   = new_bit_rqst   && (sel == 1);
  assign bus2.new_bit_rqst   = new_bit_rqst   && (sel == 2);
  assign bus0.new_frame_rqst = new_frame_rqst && (sel == 0);
  assign bus1.new_frame_rqst = new_frame_rqst && (sel == 1);
  assign bus2.new_frame_rqst = new_frame_rqst && (sel == 2);

  // Pixel RAM: data valid one cycle after the strobe, inverted garbage otherwise.
  always @(posedge clk) begin
    bus0.pix_data <= bus0.pix_rd_en ? mem[bus0.pix_addr] : ~mem[bus0.pix_addr];
    bus1.pix_data <= bus1.pix_rd_en ? mem[bus1.pix_addr] : ~mem[bus1.pix_addr];
    bus2.pix_data <= bus2.pix_rd_en ? mem[bus2.pix_addr] : ~mem[bus2.pix_addr];
  end

  logic       m_bit, m_abs, m_busy, m_done, m_rd;
  logic [5:0] m_addr;
  always_comb begin
    case (sel)
      1: begin
        m_bit = bus1.bit_to_transmit; m_abs = bus1.all_bits_shifted; m_busy = bus1.frame_busy;
        m_done = bus1.frame_done; m_rd = bus1.pix_rd_en; m_addr = bus1.pix_addr;
      end
      2: begin
        m_bit = bus2.bit_to_transmit; m_abs = bus2.all_bits_shifted; m_busy = bus2.frame_busy;
        m_done = bus2.frame_done; m_rd = bus2.pix_rd_en; m_addr = bus2.pix_addr;
      end
      default: begin
        m_bit = bus0.bit_to_transmit; m_abs = bus0.all_bits_shifted; m_busy = bus0.frame_busy;
        m_done = bus0.frame_done; m_rd = bus0.pix_rd_en; m_addr = bus0.pix_addr;
      end
    endcase
  end

  always @(posedge clk) begin
    if (m_rd) begin
      rd_log[rd_total[7:0]] <= m_addr;
      rd_total <= rd_total + 1;
    end
    if (m_done) done_total <= done_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    new_frame_rqst = 1'b1;
    tick();
    new_frame_rqst = 1'b0;
  endtask

  task automatic pulse_bit();
    new_bit_rqst = 1'b1;
    tick();
    new_bit_rqst = 1'b0;
  endtask

  task automatic push_pixel(input logic [23:0] px);
    for (int b = 23; b >= 0; b--) exp_q.push_back(px[b]);
  endtask

  task automatic wait_shift();
    int n = 0;
    while (m_abs === 1'b1 && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_cmp++;
      if ({m_bit, m_abs, m_busy, m_done, m_rd, m_addr} !== {5'b01000, 6'd0}) begin
        n_err++;
        $display("FAIL reset dut%0d: bit/abs/busy/done/rd/addr = %b%b%b%b%b/%0d, required 01000/0",
                 s, m_bit, m_abs, m_busy, m_done, m_rd, m_addr);
      end
    end
    sel = 0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    int  rd0;
    logic e;
    sel = 0;
    mem[0] = 24'hA50000;
    mem[1] = 24'h00FF01;
    exp_q.delete();
    push_pixel(mem[0]);
    push_pixel(mem[1]);
    rd0 = rd_total;
    frame_ready = 1'b1;
    pulse_frame();
    wait_shift();
    for (int k = 0; k <= 48; k++) begin
      if (k > 0) pulse_bit();
      if (k < 48) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (m_bit !== e) begin
          n_err++;
          $display("FAIL basic bit %0d: got %b, required %b", k, m_bit, e);
        end
      end
      n_cmp++;
      if (m_abs !== (k == 48)) begin
        n_err++;
        $display("FAIL basic all_bits_shifted after pulse %0d: got %b, required %b", k, m_abs, k == 48);
      end
      if (k < 48) repeat (9) tick();
    end
    n_cmp++;
    if (m_bit !== 1'b0) begin
      n_err++;
      $display("FAIL basic idle bit after frame: got %b, required 0", m_bit);
    end
    n_cmp++;
    if (rd_total - rd0 !== 2 || rd_log[rd0[7:0]] !== 6'd0 || rd_log[rd0[7:0] + 8'd1] !== 6'd1) begin
      n_err++;
      $display("FAIL basic strobes: count %0d addr %0d,%0d, required 2 addr 0,1",
               rd_total - rd0, rd_log[rd0[7:0]], rd_log[rd0[7:0] + 8'd1]);
    end
  endtask

  task automatic test_end_of_frame();
    frame_ready = 1'b0;
    pulse_frame();
    n_cmp++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      n_err++;
      $display("FAIL eof pulse: done=%b busy=%b, required done=1 busy=0", m_done, m_busy);
    end
    tick();
    n_cmp++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      n_err++;
      $display("FAIL eof width: done=%b busy=%b, required done=0 busy=0", m_done, m_busy);
    end
  endtask

  task automatic test_start_gating();
    int rd0;
    int bad = 0;
    pulse_frame();
    rd0 = rd_total;
    repeat (50) begin
      tick();
      if (m_rd !== 1'b0 || m_abs !== 1'b1 || m_busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0 || rd_total != rd0) begin
      n_err++;
      $display("FAIL gating: %0d bad cycles, %0d strobes, required 0 and 0", bad, rd_total - rd0);
    end
    frame_ready = 1'b1;
    tick();
    n_cmp++;
    if (m_rd !== 1'b1 || m_addr !== 6'd0 || m_busy !== 1'b1) begin
      n_err++;
      $display("FAIL gating release: rd=%b addr=%0d busy=%b, required 1/0/1", m_rd, m_addr, m_busy);
    end
  endtask

  task automatic test_mid_frame_reset();
    int   done0;
    logic e;
    exp_q.delete();
    push_pixel(mem[0]);
    wait_shift();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        pulse_bit();
        repeat (3) tick();
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (m_bit !== e) begin
        n_err++;
        $display("FAIL midrst bit %0d: got %b, required %b", k, m_bit, e);
      end
    end
    done0 = done_total;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({m_bit, m_abs, m_busy, m_done, m_rd, m_addr} !== {5'b01000, 6'd0}) begin
      n_err++;
      $display("FAIL midrst outputs: bit/abs/busy/done/rd/addr = %b%b%b%b%b/%0d, required 01000/0",
               m_bit, m_abs, m_busy, m_done, m_rd, m_addr);
    end
    repeat (5) tick();
    n_cmp++;
    if (done_total != done0) begin
      n_err++;
      $display("FAIL midrst frame_done: %0d pulses, required 0", done_total - done0);
    end
    pulse_frame();
    n_cmp++;
    if (m_rd !== 1'b1 || m_addr !== 6'd0) begin
      n_err++;
      $display("FAIL midrst restart: rd=%b addr=%0d, required 1/0", m_rd, m_addr);
    end
    frame_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   rd0;
    logic e;
    sel = 1;
    mem[0] = 24'h123456;
    mem[1] = 24'hC3A5F0;
    mem[2] = 24'h0F0F81;
    tick();
    exp_q.delete();
    for (int p = 0; p < 3; p++) push_pixel(mem[p]);
    rd0 = rd_total;
    frame_ready = 1'b1;
    pulse_frame();
    wait_shift();
    for (int k = 0; k <= 72; k++) begin
      if (k > 0) pulse_bit();
      if (k < 72) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (m_bit !== e) begin
          n_err++;
          $display("FAIL b2b bit %0d: got %b, required %b", k, m_bit, e);
        end
        repeat (3) tick();
      end
    end
    n_cmp++;
    if (m_abs !== 1'b1) begin
      n_err++;
      $display("FAIL b2b all_bits_shifted: got %b, required 1", m_abs);
    end
    n_cmp++;
    if (rd_total - rd0 !== 3 || rd_log[rd0[7:0]] !== 6'd0 || rd_log[rd0[7:0] + 8'd1] !== 6'd1 ||
        rd_log[rd0[7:0] + 8'd2] !== 6'd2) begin
      n_err++;
      $display("FAIL b2b strobes: count %0d, required 3 at addr 0,1,2", rd_total - rd0);
    end
    frame_ready = 1'b0;
    pulse_frame();
    n_cmp++;
    if (m_done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b frame_done: got %b, required 1", m_done);
    end
  endtask

  task automatic test_single_led();
    int   rd0;
    logic e;
    sel = 2;
    mem[0] = 24'h800001;
    tick();
    exp_q.delete();
    push_pixel(mem[0]);
    rd0 = rd_total;
    frame_ready = 1'b1;
    pulse_frame();
    wait_shift();
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) pulse_bit();
      if (k < 24) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (m_bit !== e) begin
          n_err++;
          $display("FAIL single bit %0d: got %b, required %b", k, m_bit, e);
        end
        repeat (3) tick();
      end
    end
    n_cmp++;
    if (m_abs !== 1'b1 || rd_total - rd0 !== 1) begin
      n_err++;
      $display("FAIL single end: abs=%b strobes=%0d, required abs=1 strobes=1", m_abs, rd_total - rd0);
    end
    pulse_frame();
    n_cmp++;
    if (m_done !== 1'b1) begin
      n_err++;
      $display("FAIL single frame_done: got %b, required 1", m_done);
    end
    tick();
    n_cmp++;
    if (m_rd !== 1'b1 || m_addr !== 6'd0 || m_busy !== 1'b1) begin
      n_err++;
      $display("FAIL single next frame: rd=%b addr=%0d busy=%b, required 1/0/1", m_rd, m_addr, m_busy);
    end
    frame_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_end_of_frame();
    test_start_gating();
    test_mid_frame_reset();
    test_back_to_back();
    test_single_led();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
`default_nettype wire
